// File: rtl/rename_recovery_ctrl.sv
// Rename-state recovery sequencer: after a flush it walks the committed map into the
// speculative map, tracks which physical registers are live, then reloads the free list.
module rename_recovery_ctrl #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 48,
   parameter int ARCH_W    = $clog2(ARCH_REGS),
   parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_req,
   input  logic                 cmt_update,
   output logic [ARCH_W-1:0]    cmt_rd_arch,
   input  logic [PHYS_W-1:0]    cmt_rd_phys,
   output logic                 map_wr_en,
   output logic [ARCH_W-1:0]    map_wr_arch,
   output logic [PHYS_W-1:0]    map_wr_phys,
   output logic                 fl_load,
   output logic [PHYS_REGS-1:0] fl_free_mask,
   output logic                 rename_stall,
   output logic                 recover_done,
   output logic                 map_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WALK,
      S_LOAD
   } state_t;

   localparam logic [ARCH_W-1:0]    IDX_FIRST  = ARCH_W'(1);
   localparam logic [ARCH_W-1:0]    IDX_LAST   = ARCH_W'(ARCH_REGS - 1);
   localparam logic [PHYS_REGS-1:0] INUSE_INIT = PHYS_REGS'(1);
   localparam logic [PHYS_W:0]      PHYS_LIM   = (PHYS_W + 1)'(PHYS_REGS);

   state_t                 state_q, state_d;
   logic [ARCH_W-1:0]      idx_q, idx_d;
   logic [PHYS_REGS-1:0]   inuse_q, inuse_d;
   logic                   map_err_q, map_err_d;
   logic                   restart;
   logic                   phys_ok;

   // Any flush or committed-map change invalidates the partially built state.
   assign restart = flush_req | cmt_update;
   assign phys_ok = ({1'b0, cmt_rd_phys} < PHYS_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= IDX_FIRST;
         inuse_q   <= INUSE_INIT;
         map_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         inuse_q   <= inuse_d;
         map_err_q <= map_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      inuse_d      = inuse_q;
      map_err_d    = map_err_q;
      cmt_rd_arch  = '0;
      map_wr_en    = 1'b0;
      map_wr_arch  = '0;
      map_wr_phys  = '0;
      fl_load      = 1'b0;
      fl_free_mask = '0;
      recover_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_WALK;
               idx_d   = IDX_FIRST;
               inuse_d = INUSE_INIT;
            end
         end
         S_WALK: begin
            cmt_rd_arch = idx_q;
            map_wr_en   = 1'b1;
            map_wr_arch = idx_q;
            map_wr_phys = cmt_rd_phys;
            if (phys_ok) begin
               inuse_d[cmt_rd_phys] = 1'b1;
            end else begin
               map_err_d = 1'b1;
            end
            // Restart wins over the terminal step; this cycle's write is redone later.
            if (restart) begin
               idx_d   = IDX_FIRST;
               inuse_d = INUSE_INIT;
            end else if (idx_q == IDX_LAST) begin
               state_d = S_LOAD;
               idx_d   = IDX_FIRST;
            end else begin
               idx_d = idx_q + IDX_FIRST;
            end
         end
         S_LOAD: begin
            if (restart) begin
               state_d = S_WALK;
               idx_d   = IDX_FIRST;
               inuse_d = INUSE_INIT;
            end else begin
               fl_load      = 1'b1;
               fl_free_mask = ~inuse_q;
               recover_done = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rename_stall = flush_req | (state_q != S_IDLE);
   assign map_err      = map_err_q;

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Directed bench for rename_recovery_ctrl: full walks, restarts from WALK and LOAD,
// out-of-range phys entries and asynchronous reset mid-walk.
module tb_rename_recovery_ctrl;

   localparam int AR = 32;
   localparam int PR = 48;
   localparam logic [47:0] MASK_ID  = 48'hFFFF_0000_0000;
   localparam logic [47:0] MASK_X5  = 48'hFEFF_0000_0020;
   localparam logic [47:0] MASK_BAD = 48'hFFFF_0000_0080;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_req;
   logic        cmt_update;
   logic [4:0]  cmt_rd_arch;
   logic [5:0]  cmt_rd_phys;
   logic        map_wr_en;
   logic [4:0]  map_wr_arch;
   logic [5:0]  map_wr_phys;
   logic        fl_load;
   logic [47:0] fl_free_mask;
   logic        rename_stall;
   logic        recover_done;
   logic        map_err;

   logic [5:0]  cmap [AR];
   int          total  = 0;
   int          passed = 0;
   int          failed = 0;
   logic        exp_err = 1'b0;

   always #5 clk = ~clk;

   assign cmt_rd_phys = cmap[cmt_rd_arch];

   rename_recovery_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .flush_req    (flush_req),
      .cmt_update   (cmt_update),
      .cmt_rd_arch  (cmt_rd_arch),
      .cmt_rd_phys  (cmt_rd_phys),
      .map_wr_en    (map_wr_en),
      .map_wr_arch  (map_wr_arch),
      .map_wr_phys  (map_wr_phys),
      .fl_load      (fl_load),
      .fl_free_mask (fl_free_mask),
      .rename_stall (rename_stall),
      .recover_done (recover_done),
      .map_err      (map_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic f, input logic u);
      @(negedge clk);
      flush_req  = f;
      cmt_update = u;
      #1;
   endtask

   task automatic set_identity();
      for (int i = 0; i < AR; i++) cmap[i] = 6'(i);
   endtask

   task automatic do_flush();
      step(1'b1, 1'b0);
      check("flush_stall", rename_stall, 1);
      check("flush_wr_en", map_wr_en, 0);
      check("flush_fl_load", fl_load, 0);
   endtask

   task automatic walk_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step(1'b0, 1'b0);
         check("walk_en", map_wr_en, 1);
         check("walk_arch", map_wr_arch, i);
         check("walk_phys", map_wr_phys, cmap[i]);
         check("walk_rd_arch", cmt_rd_arch, i);
         check("walk_stall", rename_stall, 1);
         check("walk_fl_load", fl_load, 0);
         check("walk_err", map_err, exp_err);
         if (cmap[i] >= 6'(PR)) exp_err = 1'b1;
      end
   endtask

   task automatic check_load(input logic [47:0] m);
      step(1'b0, 1'b0);
      check("load_fl_load", fl_load, 1);
      check("load_done", recover_done, 1);
      check("load_mask", fl_free_mask, m);
      check("load_stall", rename_stall, 1);
      check("load_wr_en", map_wr_en, 0);
      check("load_rd_arch", cmt_rd_arch, 0);
      step(1'b0, 1'b0);
      check("idle_stall", rename_stall, 0);
      check("idle_fl_load", fl_load, 0);
      check("idle_done", recover_done, 0);
      check("idle_mask", fl_free_mask, 0);
   endtask

   initial begin
      reset      = 1'b1;
      flush_req  = 1'b0;
      cmt_update = 1'b0;
      set_identity();
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", rename_stall, 0);
      check("rst_wr_en", map_wr_en, 0);
      check("rst_fl_load", fl_load, 0);
      check("rst_done", recover_done, 0);
      check("rst_mask", fl_free_mask, 0);
      check("rst_rd_arch", cmt_rd_arch, 0);
      check("rst_err", map_err, 0);
      @(negedge clk);
      reset = 1'b0;

      // cmt_update alone does nothing in IDLE
      step(1'b0, 1'b1);
      check("idle_upd_stall", rename_stall, 0);
      step(1'b0, 1'b0);
      check("idle_upd_wr_en", map_wr_en, 0);
      check("idle_upd_stall2", rename_stall, 0);

      // T1: identity map
      do_flush();
      walk_range(1, 31);
      check_load(MASK_ID);

      // T2: x5 -> p40
      cmap[5] = 6'd40;
      do_flush();
      walk_range(1, 31);
      check_load(MASK_X5);
      set_identity();

      // T3: flush at idx 20; the stale p45 mapping must not survive the restart
      cmap[3] = 6'd45;
      do_flush();
      walk_range(1, 19);
      cmap[3] = 6'd3;
      step(1'b1, 1'b0);
      check("t3_restart_arch", map_wr_arch, 20);
      check("t3_restart_en", map_wr_en, 1);
      check("t3_restart_fl", fl_load, 0);
      walk_range(1, 31);
      check_load(MASK_ID);

      // T4: cmt_update in LOAD suppresses the reload and restarts
      do_flush();
      walk_range(1, 31);
      cmap[5] = 6'd40;
      step(1'b0, 1'b1);
      check("t4_fl_load", fl_load, 0);
      check("t4_done", recover_done, 0);
      check("t4_mask", fl_free_mask, 0);
      check("t4_stall", rename_stall, 1);
      walk_range(1, 31);
      check_load(MASK_X5);
      set_identity();

      // T5: out-of-range phys at idx 7
      cmap[7] = 6'd50;
      do_flush();
      walk_range(1, 31);
      check_load(MASK_BAD);
      step(1'b0, 1'b0);
      check("t5_err_sticky", map_err, 1);
      set_identity();

      // T6: asynchronous reset at idx 15
      do_flush();
      walk_range(1, 14);
      step(1'b0, 1'b0);
      check("t6_arch15", map_wr_arch, 15);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_wr_en", map_wr_en, 0);
      check("t6_rst_rd_arch", cmt_rd_arch, 0);
      check("t6_rst_stall", rename_stall, 0);
      check("t6_rst_err", map_err, 0);
      check("t6_rst_fl_load", fl_load, 0);
      exp_err = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 34; c++) begin
         step(1'b0, 1'b0);
         check("t6_quiet_fl", fl_load, 0);
         check("t6_quiet_stall", rename_stall, 0);
      end
      do_flush();
      walk_range(1, 31);
      check_load(MASK_ID);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
